gray_to_binary_pipe: RTL and testbench
======================================

// Module: gray_to_binary_pipe
// PURPOSE
//   Two-stage pipelined Gray-to-binary decoder with valid/ready flow control.
//   Receive-side counterpart of binary_to_gray: turns Gray-coded pointers/tags
//   from the router datapath back into binary.
//   Checks that consecutive accepted codes differ by exactly one bit; flags and
//   counts violations.
// PARAMETERS
//   WIDTH      4   code width in bits (>=2)
//   ERR_CNT_W  8   width of saturating step-error counter
// PORTS
//   clk        in   1          single clock; all logic on rising edge
//   rst        in   1          synchronous, active-high reset
//   in_valid   in   1          gray_in holds a valid code
//   in_ready   out  1          block accepts gray_in this cycle
//   gray_in    in   WIDTH      Gray-coded input
//   out_valid  out  1          bin_out/step_err valid
//   out_ready  in   1          consumer accepts output this cycle
//   bin_out    out  WIDTH      decoded binary value
//   step_err   out  1          this word's Hamming distance to previous accepted code != 1
//   err_cnt    out  ERR_CNT_W  saturating count of step_err words delivered
// BEHAVIOUR
//   Reset: in_ready=1 (comb. from empty pipe), out_valid=0, bin_out=0,
//     step_err=0, err_cnt=0, prev-code history cleared, first_flag=1.
//   Handshake: transfer when valid&&ready on the same edge.
//     in_valid must not depend on in_ready; out_ready may change freely.
//   S1 (capture): on accept, s1_gray<=gray_in.
//     s1_err <= !first_flag && (popcount(gray_in ^ prev_gray) != 1).
//     Then prev_gray<=gray_in and first_flag<=0.
//   S2 (decode): b[W-1]=g[W-1]; b[i]=b[i+1]^g[i] (prefix XOR).
//     Registered into bin_out with step_err<=s1_err.
//   Advance: s2_adv = !out_valid || out_ready;
//     s1_adv = !s1_valid || s2_adv; in_ready = s1_adv.
//   Latency: 2 cycles from input accept to out_valid when unstalled.
//     Throughput 1 word/cycle.
//   Stall: with out_ready=0, bin_out/step_err hold stable.
//     Pipe holds at most 2 words, then in_ready=0. No drop, no duplicate.
//   err_cnt increments when an output with step_err=1 is transferred
//     (out_valid&&out_ready). Saturates at all-ones, no wrap.
//   Wrap-around: max-code -> 0 Gray transition (e.g. 1000->0000, W=4) is
//     distance 1, so no error. A repeated identical code is distance 0, so error.
//   Simultaneous accept and output transfer in one cycle: both complete;
//     occupancy unchanged.
//   Reset mid-operation: in-flight words discarded. First word after reset
//     is error-exempt.
//   No gaps inserted; bubbles on in_valid propagate as out_valid=0.
// STRUCTURE
//   Shared include router_gray_defs.vh: default WIDTH, ERR_CNT_W.
//   Sub-module gray_step_check: popcount(a^b)==1 compare, combinational.
//     Reusable by the encoder side.
//   Decode loop and handshake regs stay in this module.
// TESTING (WIDTH=4)
//   1. Reset, out_ready=1, stream 0000,0001,0011,0010,0110 -> bin_out
//      0,1,2,3,4 two cycles after each accept; step_err=0; err_cnt=0.
//   2. Stream 0000 then 0011 -> second output bin=2, step_err=1; err_cnt=1.
//      Repeat 0011 -> step_err=1, err_cnt=2.
//   3. Wrap: 1001,1000,0000 (14,15,0) -> bins 14,15,0, no step_err.
//   4. Backpressure: out_ready=0 for 5 cycles with in_valid=1 ->
//      in_ready drops after 2 accepts; first output held stable.
//      Release -> all words in order, none lost or duplicated.
//   5. Force err_cnt to 255 via 300 bad steps -> saturates at 8'hFF.
//   6. Assert rst with 2 words in flight -> next cycle out_valid=0, err_cnt=0.
//      Next word 0101 (any) -> bin 6, step_err=0.

Source files
------------

// File: rtl/gray_to_binary_pipe_pkg.sv
// Shared defaults for the Gray-code receive path.
// Used by the decoder pipe and the step checker.
package gray_to_binary_pipe_pkg;

  localparam int unsigned GRAY_WIDTH_DEF     = 4;
  localparam int unsigned GRAY_ERR_CNT_W_DEF = 8;

endpackage

// File: rtl/gray_step_check.sv
// Flags a single-bit step between two Gray codes.
// Pure combinational; shared with the encoder side.
module gray_step_check
  import gray_to_binary_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = GRAY_WIDTH_DEF
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_one
);

  logic [WIDTH-1:0] w_x;

  // one-hot test: nonzero and clearing the lowest set bit leaves zero
  always_comb begin
    w_x   = i_a ^ i_b;
    o_one = (w_x != '0) &&
            ((w_x & (w_x - WIDTH'(1))) == '0);
  end

endmodule

// File: rtl/gray_to_binary_pipe.sv
// Two-stage Gray-to-binary decoder with valid/ready.
// Checks single-bit steps and counts violations.
module gray_to_binary_pipe
  import gray_to_binary_pipe_pkg::*;
#(
  parameter int unsigned WIDTH     = GRAY_WIDTH_DEF,
  parameter int unsigned ERR_CNT_W = GRAY_ERR_CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     gray_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     bin_out,
  output logic                 step_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  logic                 r_s1_valid;
  logic [WIDTH-1:0]     r_s1_gray;
  logic                 r_s1_err;
  logic [WIDTH-1:0]     r_prev_gray;
  logic                 r_first;
  logic                 r_out_valid;
  logic [WIDTH-1:0]     r_bin;
  logic                 r_step_err;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  logic                 w_s2_adv;
  logic                 w_s1_adv;
  logic                 w_acc;
  logic                 w_xfer;
  logic                 w_one;
  logic [WIDTH-1:0]     w_bin;

  gray_step_check #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_a   (gray_in),
    .i_b   (r_prev_gray),
    .o_one (w_one)
  );

  // pipeline advance and handshake terms
  always_comb begin
    w_s2_adv = !r_out_valid || out_ready;
    w_s1_adv = !r_s1_valid || w_s2_adv;
    w_acc    = in_valid && w_s1_adv;
    w_xfer   = r_out_valid && out_ready;
  end

  // prefix XOR from the MSB: bit i is parity of g[W-1:i]
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_dec
    assign w_bin[gi] = ^(r_s1_gray >> gi);
  end

  // capture stage plus previous-code history
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_gray   <= '0;
      r_s1_err    <= 1'b0;
      r_prev_gray <= '0;
      r_first     <= 1'b1;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_gray   <= gray_in;
        r_s1_err    <= !r_first && !w_one;
        r_prev_gray <= gray_in;
        r_first     <= 1'b0;
      end
    end
  end

  // decode stage; holds while the consumer stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_bin       <= '0;
      r_step_err  <= 1'b0;
    end else if (w_s2_adv) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_bin      <= w_bin;
        r_step_err <= r_s1_err;
      end
    end
  end

  // saturating count of delivered error words
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if (w_xfer && r_step_err &&
                 (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
    end
  end

  assign in_ready  = w_s1_adv;
  assign out_valid = r_out_valid;
  assign bin_out   = r_bin;
  assign step_err  = r_step_err;
  assign err_cnt   = r_err_cnt;

  logic w_unused;
  assign w_unused = w_acc;

endmodule

// File: tb/tb_gray_to_binary_pipe.sv
// Directed bench for gray_to_binary_pipe (WIDTH=4).
// Table vectors plus hand-written stall/reset sequences.
module tb_gray_to_binary_pipe;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] gray_in;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] bin_out;
  logic       step_err;
  logic [7:0] err_cnt;

  gray_to_binary_pipe #(
    .WIDTH     (4),
    .ERR_CNT_W (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .gray_in   (gray_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bin_out   (bin_out),
    .step_err  (step_err),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] g;
    logic [3:0] bin;
    logic       err;
  } vec_t;

  vec_t tbl [11];
  int   n_tests;
  int   n_fail;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic do_reset(input bit check);
    @(negedge clk);
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    if (check) begin
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_bin", 32'(bin_out), 0);
      chk("rst_step_err", 32'(step_err), 0);
      chk("rst_err_cnt", 32'(err_cnt), 0);
      chk("rst_in_ready", 32'(in_ready), 1);
    end
  endtask

  // stream tbl[lo +: n] back to back, outputs due 2 cycles later
  task automatic run_group(input int lo, input int n);
    for (int c = 0; c < n + 2; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      if (c < n) begin
        in_valid = 1'b1;
        gray_in  = tbl[lo + c].g;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c < n) chk("in_ready", 32'(in_ready), 1);
      if (c >= 2) begin
        chk("out_valid", 32'(out_valid), 1);
        chk("bin_out", 32'(bin_out),
            32'(tbl[lo + c - 2].bin));
        chk("step_err", 32'(step_err),
            32'(tbl[lo + c - 2].err));
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("drain_out_valid", 32'(out_valid), 0);
  endtask

  logic [3:0] seq [6];
  logic [3:0] rcv_bin [$];
  logic       rcv_err [$];
  int         acc;

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    gray_in   = 4'h0;

    tbl[0]  = '{4'b0000, 4'd0,  1'b0};
    tbl[1]  = '{4'b0001, 4'd1,  1'b0};
    tbl[2]  = '{4'b0011, 4'd2,  1'b0};
    tbl[3]  = '{4'b0010, 4'd3,  1'b0};
    tbl[4]  = '{4'b0110, 4'd4,  1'b0};
    tbl[5]  = '{4'b0000, 4'd0,  1'b0};
    tbl[6]  = '{4'b0011, 4'd2,  1'b1};
    tbl[7]  = '{4'b0011, 4'd2,  1'b1};
    tbl[8]  = '{4'b1001, 4'd14, 1'b0};
    tbl[9]  = '{4'b1000, 4'd15, 1'b0};
    tbl[10] = '{4'b0000, 4'd0,  1'b0};

    // 1: clean stream
    do_reset(1'b1);
    run_group(0, 5);
    chk("t1_err_cnt", 32'(err_cnt), 0);

    // 2: two-bit step then repeated code
    do_reset(1'b0);
    run_group(5, 3);
    chk("t2_err_cnt", 32'(err_cnt), 2);

    // 3: wrap from max code back to zero
    do_reset(1'b0);
    run_group(8, 3);
    chk("t3_err_cnt", 32'(err_cnt), 0);

    // 4: backpressure
    do_reset(1'b0);
    seq[0] = 4'b0000; seq[1] = 4'b0001;
    seq[2] = 4'b0011; seq[3] = 4'b0010;
    seq[4] = 4'b0110; seq[5] = 4'b0111;
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      gray_in   = seq[acc];
      #1;
      if (c >= 2) begin
        chk("bp_in_ready", 32'(in_ready), 0);
        chk("bp_out_valid", 32'(out_valid), 1);
        chk("bp_hold_bin", 32'(bin_out), 0);
      end
      if (in_ready) acc++;
    end
    chk("bp_accepts", 32'(acc), 2);
    for (int c = 0; c < 40 && rcv_bin.size() < 6; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      if (acc < 6) begin
        in_valid = 1'b1;
        gray_in  = seq[acc];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (in_valid && in_ready) acc++;
      if (out_valid && out_ready) begin
        rcv_bin.push_back(bin_out);
        rcv_err.push_back(step_err);
      end
    end
    in_valid = 1'b0;
    chk("bp_rcv_count", 32'(rcv_bin.size()), 6);
    for (int i = 0; i < rcv_bin.size(); i++) begin
      chk("bp_rcv_bin", 32'(rcv_bin[i]), 32'(i));
      chk("bp_rcv_err", 32'(rcv_err[i]), 0);
    end

    // 5: saturate err counter with repeated codes
    do_reset(1'b0);
    for (int c = 0; c < 302; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = (c < 300);
      gray_in   = 4'b0000;
    end
    @(negedge clk);
    #1;
    chk("sat_err_cnt", 32'(err_cnt), 32'hFF);

    // 6: reset with two words in flight
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    gray_in   = 4'b0001;
    @(negedge clk);
    gray_in   = 4'b0011;
    @(negedge clk);
    in_valid  = 1'b0;
    #1;
    chk("full_in_ready", 32'(in_ready), 0);
    chk("full_out_valid", 32'(out_valid), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 0);
    chk("mid_rst_err_cnt", 32'(err_cnt), 0);
    chk("mid_rst_in_ready", 32'(in_ready), 1);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    gray_in   = 4'b0101;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("post_rst_valid", 32'(out_valid), 1);
    chk("post_rst_bin", 32'(bin_out), 6);
    chk("post_rst_err", 32'(step_err), 0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
